// File: rtl/ram_scan_reader.sv
// Timed read sequencer for the data-RAM debug port: fetches one word per dwell,
// either stepping through addresses automatically or following the manual address.
module ram_scan_reader #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int MAX_ADDR     = 127,
  parameter int DWELL_CYCLES = 100000000,
  parameter int TIMEOUT      = 15
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              en,
  input  logic              auto_mode,
  input  logic [ADDR_W-1:0] manual_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] show_data,
  output logic [ADDR_W-1:0] show_addr,
  output logic              show_stb,
  output logic              rd_err
);

  localparam int DCW = $clog2(DWELL_CYCLES + 1);
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DCW-1:0]    DWELL_END = DCW'(DWELL_CYCLES);
  localparam logic [TCW-1:0]    TO_END    = TCW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);
  localparam logic [DATA_W-1:0] ERR_WORD  = DATA_W'(32'hDEAD_DEAD);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [DCW-1:0]    dcnt;
  logic [TCW-1:0]    tcnt;

  logic [ADDR_W-1:0] start_addr, next_addr;
  logic              manual_moved;

  // IDLE resumes the auto scan where it stopped; HOLD advances it.
  always_comb begin
    start_addr   = auto_mode ? cur_addr : manual_addr;
    next_addr    = manual_addr;
    if (auto_mode)
      next_addr  = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
    manual_moved = !auto_mode && (manual_addr != show_addr);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      show_data <= '0;
      show_addr <= '0;
      show_stb  <= 1'b0;
      rd_err    <= 1'b0;
      dcnt      <= '0;
      tcnt      <= '0;
    end else begin
      rd_req   <= 1'b0;
      show_stb <= 1'b0;
      case (state)
        IDLE: if (en) begin
          cur_addr <= start_addr;
          rd_addr  <= start_addr;
          rd_req   <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Data beats a coincident timeout; en is only consulted once the read completes.
          if (rd_valid || tcnt == TO_END) begin
            show_data <= rd_valid ? rd_data : ERR_WORD;
            show_addr <= rd_addr;
            rd_err    <= !rd_valid;
            show_stb  <= 1'b1;
            dcnt      <= '0;
            state     <= en ? HOLD : IDLE;
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end
        HOLD: begin
          if (!en) begin
            state <= IDLE;
          end else if (manual_moved || dcnt == DWELL_END) begin
            cur_addr <= next_addr;
            rd_addr  <= next_addr;
            rd_req   <= 1'b1;
            state    <= REQ;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a 1-cycle-latency RAM model and
// injectable stray rd_valid pulses.
module tb_ram_scan_reader;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          sysclk = 1'b0;
  logic          reset, en, auto_mode;
  logic [AW-1:0] manual_addr;
  logic          rd_req, rd_valid, show_stb, rd_err;
  logic [AW-1:0] rd_addr, show_addr;
  logic [DW-1:0] rd_data, show_data;

  logic          m_vld = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          ram_mute, inj;
  logic [DW-1:0] ram [128];
  int            cyc = 0;
  int            ncmp = 0;
  int            nerr = 0;

  ram_scan_reader #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(3), .DWELL_CYCLES(4), .TIMEOUT(3)
  ) dut (
    .sysclk(sysclk), .reset(reset), .en(en), .auto_mode(auto_mode),
    .manual_addr(manual_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .show_data(show_data),
    .show_addr(show_addr), .show_stb(show_stb), .rd_err(rd_err)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  // RAM answers a request one cycle later unless muted.
  always @(posedge sysclk) begin
    m_vld  <= rd_req && !ram_mute;
    m_data <= ram[rd_addr];
  end
  assign rd_valid = m_vld | inj;
  assign rd_data  = inj ? 32'hBAD0_BAD0 : m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output int n, output int stbs);
    bit seen = 0;
    n = 0; stbs = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sysclk);
      n++;
      if (show_stb) stbs++;
      if (rd_req) seen = 1;
    end
    if (!seen) chk("req_timeout", 0, 1);
  endtask

  task automatic wait_stb(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sysclk);
      n++;
      if (show_stb) seen = 1;
    end
    if (!seen) chk("stb_timeout", 0, 1);
  endtask

  initial begin
    int n, s, m, prev, reqs;
    for (int i = 0; i < 128; i++) ram[i] = 32'h1000 + i;
    ram[5] = 32'hCAFE_0005;
    ram[9] = 32'h9999_0009;
    reset = 1'b1; en = 1'b0; auto_mode = 1'b1; manual_addr = '0;
    ram_mute = 1'b0; inj = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_data", show_data, 0);
    chk("rst_addr", show_addr, 0);
    chk("rst_stb", show_stb, 0);
    chk("rst_err", rd_err, 0);

    // 1: auto scan with wrap
    reset = 1'b0; en = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_req(n, s);
      if (i == 0) chk("t1_req_lat", n, 1);
      else        chk("t1_period", cyc - prev, 7);
      prev = cyc;
      chk("t1_rd_addr", rd_addr, i % 4);
      chk("t1_extra_stb", s, 0);
      wait_stb(m);
      chk("t1_stb_lat", m, 2);
      chk("t1_data", show_data, 32'h1000 + (i % 4));
      chk("t1_addr", show_addr, i % 4);
    end

    // 2: manual mode, refresh and mid-dwell address change
    en = 1'b0;
    repeat (2) @(negedge sysclk);
    auto_mode = 1'b0; manual_addr = 7'd5; en = 1'b1;
    wait_req(n, s);
    chk("t2_req_lat", n, 1);
    chk("t2_rd_addr", rd_addr, 5);
    prev = cyc;
    wait_stb(m);
    chk("t2_data", show_data, 32'hCAFE_0005);
    chk("t2_addr", show_addr, 5);
    wait_req(n, s);
    chk("t2_refresh_period", cyc - prev, 7);
    chk("t2_refresh_addr", rd_addr, 5);
    wait_stb(m);
    repeat (2) @(negedge sysclk);
    manual_addr = 7'd9;
    @(negedge sysclk);
    chk("t2_abort_req", rd_req, 1);
    chk("t2_abort_addr", rd_addr, 9);
    wait_stb(m);
    chk("t2_data9", show_data, 32'h9999_0009);

    // 3: timeout then recovery
    en = 1'b0;
    repeat (2) @(negedge sysclk);
    auto_mode = 1'b1; ram_mute = 1'b1; en = 1'b1;
    wait_req(n, s);
    chk("t3_rd_addr", rd_addr, 9);
    wait_stb(m);
    chk("t3_to_lat", m, 4);
    chk("t3_data", show_data, 32'hDEAD_DEAD);
    chk("t3_addr", show_addr, 9);
    chk("t3_err", rd_err, 1);
    ram_mute = 1'b0;
    wait_req(n, s);
    chk("t3_next_addr", rd_addr, 10);
    chk("t3_err_held", rd_err, 1);
    wait_stb(m);
    chk("t3_err_clr", rd_err, 0);
    chk("t3_good_data", show_data, 32'h100A);

    // 4: stray rd_valid in HOLD and during REQ
    @(negedge sysclk);
    inj = 1'b1;
    @(negedge sysclk);
    inj = 1'b0;
    chk("t4_hold_stb", show_stb, 0);
    chk("t4_hold_data", show_data, 32'h100A);
    @(negedge sysclk);
    chk("t4_hold_stb2", show_stb, 0);
    wait_req(n, s);
    chk("t4_rd_addr", rd_addr, 11);
    ram_mute = 1'b1; inj = 1'b1;
    @(negedge sysclk);
    inj = 1'b0;
    wait_stb(m);
    chk("t4_req_data", show_data, 32'hDEAD_DEAD);
    chk("t4_req_err", rd_err, 1);
    ram_mute = 1'b0;

    // 5: en dropped while waiting for data
    wait_req(n, s);
    chk("t5_rd_addr", rd_addr, 12);
    @(negedge sysclk);
    en = 1'b0;
    @(negedge sysclk);
    chk("t5_stb", show_stb, 1);
    chk("t5_data", show_data, 32'h100C);
    reqs = 0;
    repeat (20) begin
      @(negedge sysclk);
      if (rd_req) reqs++;
    end
    chk("t5_no_req", reqs, 0);
    chk("t5_data_kept", show_data, 32'h100C);

    // 6: reset in WAIT, late rd_valid ignored
    en = 1'b1;
    wait_req(n, s);
    chk("t6_rd_addr", rd_addr, 12);
    ram_mute = 1'b1;
    @(negedge sysclk);
    reset = 1'b1; en = 1'b0;
    @(negedge sysclk);
    reset = 1'b0; inj = 1'b1;
    chk("t6_req", rd_req, 0);
    chk("t6_rd_addr0", rd_addr, 0);
    chk("t6_data", show_data, 0);
    chk("t6_addr", show_addr, 0);
    chk("t6_err", rd_err, 0);
    @(negedge sysclk);
    inj = 1'b0;
    chk("t6_stb", show_stb, 0);
    chk("t6_data_late", show_data, 0);
    @(negedge sysclk);
    chk("t6_stb2", show_stb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
